frame_buffer_scheduler: RTL and testbench
=========================================

Name: frame_buffer_scheduler

Overview:
- Sequences and arbitrates the single-port EBR row memory that holds the 64x64 frame.
- Two requesters share it: the display row fetch path (driven by the main display FSM per row address) and the frame loader writing one 64-entry y column per request.
- Memory is split into two banks (ping-pong); the block owns front/back bank selection and swaps banks only at frame boundaries, so the panel never shows a torn frame.

Parameters:
- RD_LAT, 2, cycles from mem_re assertion to row data valid at the EBR controller outputs.
- ROWS_HALF, 32, row offset between upper and lower panel halves.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd_req  in  1  display requests row pair for rd_addr (single-cycle pulse)
- rd_addr  in  5  panel row address 0..31
- rd_valid  out  1  one-cycle pulse: row_0/row_1 data valid
- rd_err  out  1  sticky: rd_req received while a read is in flight
- wr_req  in  1  loader has a column to write (held until accepted)
- wr_last  in  1  qualifies wr_req: this is the final column of the frame
- wr_ready  out  1  write accepted this cycle when wr_req&wr_ready
- mem_we  out  1  EBR write enable (one cycle per accepted write)
- mem_re  out  1  EBR read enable (one cycle per granted read)
- mem_bank  out  1  bank addressed by the current access
- row_0_sel  out  6  upper-half row select
- row_1_sel  out  6  lower-half row select
- front_bank  out  1  bank currently displayed
- back_full  out  1  back bank holds a complete, unswapped frame
- frame_cnt  out  8  completed-swap counter, wraps 255->0

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; front_bank=0; back_full=0; frame_cnt=0; rd_err=0; row selects 0.
- States: IDLE, READ, READ_WAIT, WRITE.
- IDLE priority: a captured read request beats a write. rd_req is captured in a one-deep pending flag the same cycle it arrives, in any state.
- Grant read: row_0_sel={1'b0,rd_addr}, row_1_sel=rd_addr+ROWS_HALF (6-bit), mem_bank=front_bank, mem_re=1 for one cycle -> READ_WAIT.
- READ_WAIT: counts RD_LAT-1 further cycles. rd_valid pulses exactly RD_LAT cycles after the mem_re cycle, then -> IDLE.
  - Row selects hold stable from grant through the rd_valid cycle.
- rd_req arriving while the pending flag is set or a read is in READ/READ_WAIT: sets rd_err (cleared only by reset). The extra request is dropped.
- Write acceptance: wr_ready=1 only in IDLE, with no read pending and back_full=0. On wr_req&wr_ready:
  - mem_we=1, mem_bank=~front_bank, -> WRITE for one cycle -> IDLE.
  - The column write is one memory cycle, so writes occupy 2 cycles including IDLE.
- If wr_last is accepted: back_full=1 from the next cycle; wr_ready stays 0 until the swap.
- Swap: when a read is granted with rd_addr==0 and back_full=1, then in that same grant cycle:
  - front_bank toggles, back_full clears, frame_cnt increments.
  - mem_bank for this read already uses the new front_bank.
- Swap never occurs for rd_addr!=0; the display completes the current frame from the old bank.
- rd_req and wr_req in the same IDLE cycle: read granted, write waits (wr_ready=0).
- Reset mid-access: the in-flight access is abandoned, no rd_valid is produced, the bank returns to 0, and the back-bank contents are treated as empty.

Test Plan:
- Reset release, rd_req rd_addr=5 -> mem_re 1 cycle with row_0_sel=5, row_1_sel=37, mem_bank=0; rd_valid exactly 2 cycles later; rd_err=0.
- rd_req addr=31 -> row_1_sel=63; rd_req addr=0 -> row_1_sel=32, no 6-bit overflow.
- 64 writes (last with wr_last) -> 64 mem_we pulses with mem_bank=1; back_full=1; wr_ready stays 0 with wr_req held.
- Then rd_req addr=7 -> no swap, mem_bank=0. Then rd_req addr=0 -> front_bank=1, mem_bank=1, frame_cnt=1, back_full=0, wr_ready returns 1.
- rd_req and wr_req asserted in the same cycle -> read granted first; write accepted after rd_valid; no overlapping mem_re/mem_we.
- Second rd_req 1 cycle after the first -> rd_err=1 and sticky; only one rd_valid.
- Assert reset during READ_WAIT -> all outputs 0 immediately; no rd_valid after release.

Source files
------------

// File: rtl/frame_buffer_scheduler.sv
// Arbitrates the single-port ping-pong frame EBR between display row reads and loader column writes.
// Owns front/back bank selection and swaps only when a frame is complete and the display restarts at row 0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitration: a pending read wins, otherwise accept a write
// READ      | mem_re cycle for the granted row pair
// READ_WAIT | EBR read latency countdown, rd_valid on terminal count
// WRITE     | second cycle of a column write, memory busy
module frame_buffer_scheduler #(
  parameter int RD_LAT    = 2,
  parameter int ROWS_HALF = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [4:0] rd_addr,
  output logic       rd_valid,
  output logic       rd_err,
  input  logic       wr_req,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic       mem_we,
  output logic       mem_re,
  output logic       mem_bank,
  output logic [5:0] row_0_sel,
  output logic [5:0] row_1_sel,
  output logic       front_bank,
  output logic       back_full,
  output logic [7:0] frame_cnt
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    READ_WAIT = 2'd2,
    WRITE     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pend;
  logic [4:0]    r_pend_addr;
  logic [5:0]    r_row_0;
  logic [5:0]    r_row_1;
  logic          r_front;
  logic          r_back_full;
  logic [7:0]    r_frame_cnt;
  logic          r_rd_err;
  logic [CW-1:0] r_cnt;

  logic          w_rd_busy;
  logic          w_rd_pend;
  logic          w_rd_err_evt;
  logic [4:0]    w_grant_addr;
  logic          w_grant;
  logic          w_wr_ready;
  logic          w_wr_acc;
  logic          w_swap;
  logic          w_cnt_tc;

  assign w_rd_busy    = (r_state == READ) || (r_state == READ_WAIT);
  assign w_rd_pend    = r_pend || rd_req;
  assign w_rd_err_evt = rd_req && (r_pend || w_rd_busy);
  assign w_grant_addr = r_pend ? r_pend_addr : rd_addr;
  assign w_grant      = (r_state == IDLE) && w_rd_pend;
  // Gated by reset so the handshake is silent while the block is held in reset.
  assign w_wr_ready   = reset && (r_state == IDLE) && !w_rd_pend && !r_back_full;
  assign w_wr_acc     = wr_req && w_wr_ready;
  assign w_swap       = w_grant && (w_grant_addr == 5'd0) && r_back_full;
  assign w_cnt_tc     = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = READ;
        end else if (w_wr_acc) begin
          w_state_nxt = WRITE;
        end
      end
      READ:      w_state_nxt = READ_WAIT;
      READ_WAIT: if (w_cnt_tc) w_state_nxt = IDLE;
      WRITE:     w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= 1'b0;
      r_pend_addr <= 5'd0;
      r_rd_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_pend <= 1'b0;
      end else if (rd_req && !w_rd_err_evt) begin
        r_pend      <= 1'b1;
        r_pend_addr <= rd_addr;
      end
      if (w_rd_err_evt) begin
        r_rd_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_0 <= 6'd0;
      r_row_1 <= 6'd0;
      r_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_row_0 <= {1'b0, w_grant_addr};
        r_row_1 <= {1'b0, w_grant_addr} + 6'(ROWS_HALF);
      end
      if (r_state == READ) begin
        r_cnt <= CW'(RD_LAT - 1);
      end else if ((r_state == READ_WAIT) && !w_cnt_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Swap is registered on the grant edge so the mem_re cycle already sees the new front bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_front     <= 1'b0;
      r_back_full <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_swap) begin
        r_front     <= ~r_front;
        r_back_full <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (w_wr_acc && wr_last) begin
        r_back_full <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_bank = 1'b0;
    if (r_state == READ) begin
      mem_bank = r_front;
    end else if (w_wr_acc) begin
      mem_bank = ~r_front;
    end
  end

  assign mem_re     = (r_state == READ);
  assign mem_we     = w_wr_acc;
  assign wr_ready   = w_wr_ready;
  assign rd_valid   = (r_state == READ_WAIT) && w_cnt_tc;
  assign rd_err     = r_rd_err;
  assign row_0_sel  = r_row_0;
  assign row_1_sel  = r_row_1;
  assign front_bank = r_front;
  assign back_full  = r_back_full;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench for frame_buffer_scheduler: read grants are queued at request time and checked at mem_re.
module tb_frame_buffer_scheduler;

  localparam int RD_LAT = 2;

  logic       clk;
  logic       reset;
  logic       rd_req;
  logic [4:0] rd_addr;
  logic       rd_valid;
  logic       rd_err;
  logic       wr_req;
  logic       wr_last;
  logic       wr_ready;
  logic       mem_we;
  logic       mem_re;
  logic       mem_bank;
  logic [5:0] row_0_sel;
  logic [5:0] row_1_sel;
  logic       front_bank;
  logic       back_full;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [12:0] exp_q[$];

  frame_buffer_scheduler #(.RD_LAT(RD_LAT), .ROWS_HALF(32)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_err(rd_err), .wr_req(wr_req), .wr_last(wr_last),
    .wr_ready(wr_ready), .mem_we(mem_we), .mem_re(mem_re), .mem_bank(mem_bank),
    .row_0_sel(row_0_sel), .row_1_sel(row_1_sel), .front_bank(front_bank),
    .back_full(back_full), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] exp_entry(input logic [4:0] addr, input logic bank);
    logic [5:0] r0;
    r0 = {1'b0, addr};
    return {bank, r0, r0 + 6'd32};
  endfunction

  task automatic run_read(input logic [4:0] addr, input logic exp_bank, input string name);
    logic [12:0] e;
    bit seen_re, seen_v;
    int t_re;
    exp_q.push_back(exp_entry(addr, exp_bank));
    @(posedge clk); #1; rd_req = 1'b1; rd_addr = addr;
    @(posedge clk); #1; rd_req = 1'b0;
    seen_re = 0; t_re = 0;
    for (int i = 0; i < 8 && !seen_re; i++) begin
      @(negedge clk);
      if (mem_re) begin seen_re = 1; t_re = cyc; end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!seen_re) begin
      n_fail++; $display("FAIL %s_grant: mem_re never seen, required within 8 cycles", name);
    end else if ({mem_bank, row_0_sel, row_1_sel} !== e) begin
      n_fail++; $display("FAIL %s_grant: bank/row0/row1 = %0d/%0d/%0d, required %0d/%0d/%0d",
                         name, mem_bank, row_0_sel, row_1_sel, e[12], e[11:6], e[5:0]);
    end
    seen_v = 0;
    for (int i = 0; i < 8 && !seen_v; i++) begin
      @(negedge clk);
      if (rd_valid) seen_v = 1;
    end
    n_checks++;
    if (!seen_v || (cyc - t_re) != RD_LAT) begin
      n_fail++; $display("FAIL %s_latency: rd_valid seen=%0d after %0d cycles, required %0d", name, seen_v, cyc - t_re, RD_LAT);
    end
    n_checks++;
    if ({row_0_sel, row_1_sel} !== e[11:0]) begin
      n_fail++; $display("FAIL %s_rows_stable: %0d/%0d at rd_valid, required %0d/%0d", name, row_0_sel, row_1_sel, e[11:6], e[5:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_req = 1'b0; rd_addr = 5'd0; wr_req = 1'b0; wr_last = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rd_valid, rd_err, wr_ready, mem_we, mem_re, mem_bank, row_0_sel, row_1_sel, front_bank, back_full, frame_cnt} !== 28'd0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%0d err=%0d rdy=%0d we=%0d re=%0d bank=%0d r0=%0d r1=%0d front=%0d full=%0d fcnt=%0d, required all 0",
                         rd_valid, rd_err, wr_ready, mem_we, mem_re, mem_bank, row_0_sel, row_1_sel, front_bank, back_full, frame_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_wr_ready: %0d, required 1", wr_ready);
    end
  endtask

  task automatic test_row_select();
    run_read(5'd5, 1'b0, "row5");
    run_read(5'd31, 1'b0, "row31");
    run_read(5'd0, 1'b0, "row0_noswap");
    n_checks++;
    if ({rd_err, front_bank, frame_cnt} !== 10'd0) begin
      n_fail++; $display("FAIL rows_state: err=%0d front=%0d fcnt=%0d, required 0/0/0", rd_err, front_bank, frame_cnt);
    end
  endtask

  task automatic test_frame_load_swap();
    int acc, bad_bank, extra;
    acc = 0; bad_bank = 0; extra = 0;
    @(posedge clk); #1; wr_req = 1'b1; wr_last = 1'b0;
    for (int i = 0; i < 300 && acc < 64; i++) begin
      @(negedge clk);
      if (mem_we) begin
        acc++;
        if (mem_bank !== 1'b1) bad_bank++;
      end
      @(posedge clk); #1; wr_last = (acc == 63);
    end
    wr_last = 1'b0;
    n_checks++;
    if (acc != 64 || bad_bank != 0) begin
      n_fail++; $display("FAIL load_writes: %0d writes, %0d to wrong bank, required 64 and 0", acc, bad_bank);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we || wr_ready) extra++;
    end
    n_checks++;
    if (back_full !== 1'b1 || extra != 0) begin
      n_fail++; $display("FAIL load_full: back_full=%0d, %0d cycles with wr_ready/mem_we, required 1 and 0", back_full, extra);
    end
    run_read(5'd7, 1'b0, "noswap_row7");
    n_checks++;
    if ({front_bank, back_full, frame_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL noswap_state: front=%0d full=%0d fcnt=%0d, required 0/1/0", front_bank, back_full, frame_cnt);
    end
    run_read(5'd0, 1'b1, "swap_row0");
    n_checks++;
    if ({front_bank, back_full, frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL swap_state: front=%0d full=%0d fcnt=%0d, required 1/0/1", front_bank, back_full, frame_cnt);
    end
    @(posedge clk); #1; wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL swap_wr_ready: %0d, required 1", wr_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    int t_v, t_w, overlap;
    bit popped;
    t_v = -1; t_w = -1; overlap = 0; popped = 0;
    exp_q.push_back(exp_entry(5'd3, 1'b1));
    @(posedge clk); #1; rd_req = 1'b1; rd_addr = 5'd3; wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL collide_priority: wr_ready=%0d mem_we=%0d, required 0/0", wr_ready, mem_we);
    end
    @(posedge clk); #1; rd_req = 1'b0;
    for (int i = 0; i < 20 && t_w < 0; i++) begin
      @(negedge clk);
      if (mem_re && mem_we) overlap++;
      if (mem_re && !popped) begin
        e = exp_q.pop_front(); popped = 1;
        n_checks++;
        if ({mem_bank, row_0_sel, row_1_sel} !== e) begin
          n_fail++; $display("FAIL collide_grant: bank/row0/row1 = %0d/%0d/%0d, required %0d/%0d/%0d",
                             mem_bank, row_0_sel, row_1_sel, e[12], e[11:6], e[5:0]);
        end
      end
      if (rd_valid) t_v = cyc;
      if (mem_we) begin
        t_w = cyc;
        n_checks++;
        if (mem_bank !== 1'b0) begin
          n_fail++; $display("FAIL collide_wr_bank: %0d, required 0", mem_bank);
        end
      end
      if (t_w < 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; wr_req = 1'b0;
    if (!popped) void'(exp_q.pop_front());
    n_checks++;
    if (!popped || t_v < 0 || t_w <= t_v || overlap != 0) begin
      n_fail++; $display("FAIL collide_order: granted=%0d valid@%0d write@%0d overlap=%0d, required write after valid, no overlap",
                         popped, t_v, t_w, overlap);
    end
  endtask

  task automatic test_rd_err();
    int n_valid;
    n_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd_err !== 1'b0) begin
      n_fail++; $display("FAIL err_before: rd_err=%0d, required 0", rd_err);
    end
    rd_req = 1'b1; rd_addr = 5'd2;
    @(posedge clk); #1; rd_addr = 5'd9;
    @(posedge clk); #1; rd_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_valid) n_valid++;
    end
    n_checks++;
    if (rd_err !== 1'b1 || n_valid != 1) begin
      n_fail++; $display("FAIL err_overlap: rd_err=%0d rd_valid pulses=%0d, required 1 and 1", rd_err, n_valid);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (rd_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: rd_err=%0d, required 1", rd_err);
    end
  endtask

  task automatic test_reset_mid_read();
    int n_valid;
    n_valid = 0;
    @(posedge clk); #1; rd_req = 1'b1; rd_addr = 5'd4;
    @(posedge clk); #1; rd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_re !== 1'b1) begin
      n_fail++; $display("FAIL midrst_grant: mem_re=%0d, required 1", mem_re);
    end
    @(posedge clk); #1; reset = 1'b0;
    #1;
    n_checks++;
    if ({rd_valid, rd_err, wr_ready, mem_we, mem_re, mem_bank, row_0_sel, row_1_sel, front_bank, back_full, frame_cnt} !== 28'd0) begin
      n_fail++; $display("FAIL midrst_outputs: valid=%0d err=%0d rdy=%0d re=%0d r0=%0d r1=%0d front=%0d full=%0d fcnt=%0d, required all 0",
                         rd_valid, rd_err, wr_ready, mem_re, row_0_sel, row_1_sel, front_bank, back_full, frame_cnt);
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_valid) n_valid++;
    end
    n_checks++;
    if (n_valid != 0 || front_bank !== 1'b0 || back_full !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_after: rd_valid pulses=%0d front=%0d full=%0d rdy=%0d, required 0/0/0/1",
                         n_valid, front_bank, back_full, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_row_select();
    test_frame_load_swap();
    test_back_to_back();
    test_rd_err();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
